fsm_checker: RTL and testbench
==============================

# fsm_checker

Synthesizable run-time checker that sits beside the `fsm` sequencer and watches the other end of its interface: it receives the same `start`/`skip3`/`wait3` controls, runs a cycle-accurate reference model of the sequencer, and compares the model against the `zot` state code the sequencer drives. It reports sticky and pulsed error flags, captures the first mismatch, and counts completed sequences. It replaces bench-only `wait(zot==...)` checks with hardware that also works on the board.

## Interface
- `CW`, 16, width of the cycle counter and all event counters
- `RESYNC`, 1, 1 = after a mismatch on a legal code, reload the model from observed `zot`; 0 = model free-runs
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `chk_en`  in  1  1 = compare and count; 0 = model tracks, no errors, no counting
- `start`  in  1  sequencer control, same net as the sequencer input
- `skip3`  in  1  sequencer control
- `wait3`  in  1  sequencer control
- `zot`  in  3  observed sequencer state code
- `err`  out  1  sticky: any mismatch or illegal code since reset
- `err_pulse`  out  1  one-cycle pulse per detected error
- `illegal`  out  1  sticky: `zot` was outside the legal code set
- `err_cnt`  out  CW  error count, saturating at all-ones
- `seq_cnt`  out  CW  completed sequences (S3 -> IDLE), saturating
- `first_exp`  out  3  expected code at first error
- `first_got`  out  3  observed code at first error
- `first_cyc`  out  CW  value of `cyc` at first error
- `cyc`  out  CW  cycles since reset, wraps

## Operation
- Legal codes: IDLE=000, S1=010, S2=111, S3=001. All other codes are illegal.
- Model transitions, on every rising edge with inputs sampled at that edge:
  - IDLE: `start` -> S1, else IDLE
  - S1: -> S2, unconditional
  - S2: `skip3` -> S1, else S3
  - S3: `wait3` -> S3, else IDLE
- Compare: each cycle, `exp` (model state code) is compared against `zot`. Mismatch when `chk_en`=1 and `zot`!=`exp`. Illegal when `chk_en`=1 and `zot` is not a legal code. An illegal code is also a mismatch; it raises `illegal` and counts once.
- On an error: `err_pulse`=1 for one cycle, `err` set, `err_cnt`+1 with saturation. If no error has been recorded since reset, capture `first_exp`, `first_got` and `first_cyc`. Later errors do not overwrite the capture.
- Resync: with `RESYNC`=1 and a legal mismatched `zot`, the model's next state is computed from `zot` instead of `exp`. With an illegal code, the model advances from `exp`.
- `seq_cnt` increments when the model leaves S3 for IDLE and `chk_en`=1.
- `chk_en`=0: the model still advances and `cyc` still counts. All flags and counters hold.

## Timing
- Reset (`reset`=0 at an edge): model=IDLE, `cyc`=0. All outputs are 0 after that edge, including `first_*`. Reset wins over every other event. Asserting reset mid-sequence returns the model to IDLE on that edge.
- `zot` is compared against `exp` in the same cycle. The DUT and the model both update on the same edge, so there is zero model latency.
- All outputs are registered. `err_pulse`, `err`, `err_cnt`, `illegal` and `first_*` reflect a compare from cycle t at cycle t+1.
- Back-to-back errors produce `err_pulse` high on consecutive cycles, and `err_cnt` adds 1 per cycle.
- Saturation: `err_cnt` and `seq_cnt` stick at 2^CW-1. `cyc` wraps to 0.
- `skip3` and `wait3` only matter in S2 and S3 respectively; they are don't-care elsewhere. `start` is don't-care outside IDLE.
- Both the sequencer and the checker must be released from reset on the same edge. The first compare happens on the cycle after release.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles, release with `start`=0 for 10 cycles -> `zot`=000 throughout, `err`=0, `cyc`=10, `seq_cnt`=0.
- Nominal loops: pulse `start` with `skip3`=`wait3`=0 against a correct sequencer for 3 sequences -> codes 000,010,111,001,000 repeat, `seq_cnt`=3, `err_cnt`=0.
- Hold and skip: `wait3`=1 for 2 cycles in S3 -> S3 for 3 cycles. Then `skip3`=1 in S2 -> S2 to S1. Both give `err`=0.
- Injected fault: force `zot`=010 for one cycle where S2 is expected -> `err_pulse` high for 1 cycle, `first_exp`=111, `first_got`=010, `first_cyc` equals the fault cycle. With `RESYNC`=1 there are no further errors.
- Illegal code: drive `zot`=101 -> `illegal`=1, `err_cnt`+1. A second fault does not change `first_*`.
- Random soak: 1024 cycles with random `skip3` and a correct sequencer -> `err`=0. Then assert `reset` mid-S2 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/fsm_checker.sv
// Run-time checker for the fsm sequencer: a cycle-accurate reference model compared
// against the observed zot code, with sticky/pulsed error flags, first-error capture and counters.
module fsm_checker #(
    parameter int unsigned CW     = 16,
    parameter bit          RESYNC = 1'b1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          chk_en_i,
    input  logic          start_i,
    input  logic          skip3_i,
    input  logic          wait3_i,
    input  logic [2:0]    zot_i,
    output logic          err_o,
    output logic          err_pulse_o,
    output logic          illegal_o,
    output logic [CW-1:0] err_cnt_o,
    output logic [CW-1:0] seq_cnt_o,
    output logic [2:0]    first_exp_o,
    output logic [2:0]    first_got_o,
    output logic [CW-1:0] first_cyc_o,
    output logic [CW-1:0] cyc_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        S1   = 3'b010,
        S2   = 3'b111,
        S3   = 3'b001
    } state_t;

    state_t        state_q, base_c, state_d;
    logic          legal_c, mismatch_c, illegal_c, seq_done_c;
    logic          err_q, err_pulse_q, illegal_q;
    logic [CW-1:0] err_cnt_q, seq_cnt_q, first_cyc_q, cyc_q;
    logic [2:0]    first_exp_q, first_got_q;

    // Compare and reference-model next state; an illegal code never seeds the model.
    always_comb begin
        legal_c    = 1'b0;
        mismatch_c = 1'b0;
        illegal_c  = 1'b0;
        base_c     = state_q;
        state_d    = state_q;
        seq_done_c = 1'b0;

        case (zot_i)
            3'b000, 3'b010, 3'b111, 3'b001: legal_c = 1'b1;
            default:                        legal_c = 1'b0;
        endcase

        mismatch_c = chk_en_i && (zot_i != 3'(state_q));
        illegal_c  = chk_en_i && !legal_c;

        if (RESYNC && mismatch_c && legal_c) begin
            base_c = state_t'(zot_i);
        end

        case (base_c)
            IDLE:    state_d = start_i ? S1 : IDLE;
            S1:      state_d = S2;
            S2:      state_d = skip3_i ? S1 : S3;
            S3:      state_d = wait3_i ? S3 : IDLE;
            default: state_d = IDLE;
        endcase

        seq_done_c = chk_en_i && (state_q == S3) && (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            err_q       <= 1'b0;
            err_pulse_q <= 1'b0;
            illegal_q   <= 1'b0;
            err_cnt_q   <= '0;
            seq_cnt_q   <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
            first_cyc_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_q + CW'(1);
            err_pulse_q <= mismatch_c;
            if (mismatch_c) begin
                err_q <= 1'b1;
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_q <= err_cnt_q + CW'(1);
                end
                // Capture only the first error since reset.
                if (!err_q) begin
                    first_exp_q <= 3'(state_q);
                    first_got_q <= zot_i;
                    first_cyc_q <= cyc_q;
                end
            end
            if (illegal_c) begin
                illegal_q <= 1'b1;
            end
            if (seq_done_c && (seq_cnt_q != CNT_MAX)) begin
                seq_cnt_q <= seq_cnt_q + CW'(1);
            end
        end
    end

    assign err_o       = err_q;
    assign err_pulse_o = err_pulse_q;
    assign illegal_o   = illegal_q;
    assign err_cnt_o   = err_cnt_q;
    assign seq_cnt_o   = seq_cnt_q;
    assign first_exp_o = first_exp_q;
    assign first_got_o = first_got_q;
    assign first_cyc_o = first_cyc_q;
    assign cyc_o       = cyc_q;

endmodule

// File: tb/tb_fsm_checker.sv
// Directed bench for fsm_checker: a behavioural sequencer drives zot, with fault overrides,
// plus a narrow-counter instance to exercise saturation and wrap.
module tb_fsm_checker;

    localparam int unsigned CW  = 16;
    localparam int unsigned SCW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, chk_en, start, skip3, wait3, force_en;
    logic [2:0] force_val, seq_q, zot;

    logic          err, err_pulse, illegal;
    logic [CW-1:0] err_cnt, seq_cnt, first_cyc, cyc;
    logic [2:0]    first_exp, first_got;

    logic           s_err, s_err_pulse, s_illegal;
    logic [SCW-1:0] s_err_cnt, s_seq_cnt, s_first_cyc, s_cyc;
    logic [2:0]     s_first_exp, s_first_got;

    int checks = 0;
    int failures = 0;
    logic [CW-1:0] exp_cyc;

    fsm_checker #(.CW(CW), .RESYNC(1'b1)) u_dut (
        .clk_i(clk), .reset_i(reset), .chk_en_i(chk_en), .start_i(start),
        .skip3_i(skip3), .wait3_i(wait3), .zot_i(zot),
        .err_o(err), .err_pulse_o(err_pulse), .illegal_o(illegal),
        .err_cnt_o(err_cnt), .seq_cnt_o(seq_cnt), .first_exp_o(first_exp),
        .first_got_o(first_got), .first_cyc_o(first_cyc), .cyc_o(cyc)
    );

    fsm_checker #(.CW(SCW), .RESYNC(1'b1)) u_small (
        .clk_i(clk), .reset_i(reset), .chk_en_i(chk_en), .start_i(start),
        .skip3_i(skip3), .wait3_i(wait3), .zot_i(zot),
        .err_o(s_err), .err_pulse_o(s_err_pulse), .illegal_o(s_illegal),
        .err_cnt_o(s_err_cnt), .seq_cnt_o(s_seq_cnt), .first_exp_o(s_first_exp),
        .first_got_o(s_first_got), .first_cyc_o(s_first_cyc), .cyc_o(s_cyc)
    );

    // Behavioural sequencer: advances from the code it actually presents, so a forced code
    // behaves like a genuine state corruption.
    function automatic logic [2:0] seq_next(input logic [2:0] s, input logic st,
                                            input logic sk, input logic wt);
        case (s)
            3'b000:  return st ? 3'b010 : 3'b000;
            3'b010:  return 3'b111;
            3'b111:  return sk ? 3'b010 : 3'b001;
            3'b001:  return wt ? 3'b001 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) seq_q <= 3'b000;
        else        seq_q <= seq_next(zot, start, skip3, wait3);
    end

    assign zot = force_en ? force_val : seq_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!reset) exp_cyc = '0;
            else        exp_cyc = exp_cyc + CW'(1);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_err"},       32'(err),       0);
        check_eq({tag, "_pulse"},     32'(err_pulse), 0);
        check_eq({tag, "_illegal"},   32'(illegal),   0);
        check_eq({tag, "_err_cnt"},   32'(err_cnt),   0);
        check_eq({tag, "_seq_cnt"},   32'(seq_cnt),   0);
        check_eq({tag, "_first_exp"}, 32'(first_exp), 0);
        check_eq({tag, "_first_got"}, 32'(first_got), 0);
        check_eq({tag, "_first_cyc"}, 32'(first_cyc), 0);
        check_eq({tag, "_cyc"},       32'(cyc),       0);
        check_eq({tag, "_s_err_cnt"}, 32'(s_err_cnt), 0);
    endtask

    initial begin
        reset = 1'b0; chk_en = 1'b1; start = 1'b0; skip3 = 1'b0; wait3 = 1'b0;
        force_en = 1'b0; force_val = 3'b000; exp_cyc = '0;

        step(2);
        check_zero("reset");

        reset = 1'b1;
        step(10);
        check_eq("idle_cyc", 32'(cyc), 10);
        check_eq("idle_err", 32'(err), 0);
        check_eq("idle_seq", 32'(seq_cnt), 0);

        for (int i = 0; i < 3; i++) begin
            start = 1'b1; step(1);
            start = 1'b0; step(3);
        end
        check_eq("nom_seq", 32'(seq_cnt), 3);
        check_eq("nom_err_cnt", 32'(err_cnt), 0);
        check_eq("nom_cyc", 32'(cyc), 22);

        start = 1'b1; step(1);
        start = 1'b0; step(2);
        wait3 = 1'b1; step(2);
        check_eq("hold_seq_mid", 32'(seq_cnt), 3);
        wait3 = 1'b0; step(1);
        check_eq("hold_seq_end", 32'(seq_cnt), 4);

        start = 1'b1; step(1);
        start = 1'b0; step(1);
        skip3 = 1'b1; step(1);
        skip3 = 1'b0; step(3);
        check_eq("skip_seq", 32'(seq_cnt), 5);
        check_eq("skip_err", 32'(err), 0);
        check_eq("skip_cyc", 32'(cyc), 34);

        // Fault: S2 expected, sequencer shows S1 for one cycle (cyc=36).
        start = 1'b1; step(1);
        start = 1'b0; step(1);
        force_en = 1'b1; force_val = 3'b010; step(1);
        force_en = 1'b0;
        check_eq("fault_pulse", 32'(err_pulse), 1);
        check_eq("fault_err", 32'(err), 1);
        check_eq("fault_cnt", 32'(err_cnt), 1);
        check_eq("fault_first_exp", 32'(first_exp), 32'h7);
        check_eq("fault_first_got", 32'(first_got), 32'h2);
        check_eq("fault_first_cyc", 32'(first_cyc), 36);
        check_eq("fault_illegal", 32'(illegal), 0);
        step(1);
        check_eq("fault_pulse_off", 32'(err_pulse), 0);
        step(1);
        check_eq("resync_cnt", 32'(err_cnt), 1);
        check_eq("resync_seq", 32'(seq_cnt), 6);

        force_en = 1'b1; force_val = 3'b101; step(1);
        check_eq("ill_flag", 32'(illegal), 1);
        check_eq("ill_cnt", 32'(err_cnt), 2);
        check_eq("ill_pulse", 32'(err_pulse), 1);
        check_eq("ill_first_exp", 32'(first_exp), 32'h7);
        check_eq("ill_first_got", 32'(first_got), 32'h2);
        check_eq("ill_first_cyc", 32'(first_cyc), 36);
        step(1);
        check_eq("b2b_pulse", 32'(err_pulse), 1);
        check_eq("b2b_cnt", 32'(err_cnt), 3);
        step(6);
        force_en = 1'b0;
        step(1);
        check_eq("b2b_cnt_end", 32'(err_cnt), 9);
        check_eq("b2b_pulse_off", 32'(err_pulse), 0);
        check_eq("cyc_track", 32'(cyc), 32'(exp_cyc));
        check_eq("sat_s_err_cnt", 32'(s_err_cnt), 7);
        check_eq("wrap_s_cyc", 32'(s_cyc), 0);
        check_eq("wrap_s_first_cyc", 32'(s_first_cyc), 4);
        check_eq("s_seq", 32'(s_seq_cnt), 6);

        chk_en = 1'b0;
        force_en = 1'b1; force_val = 3'b101; step(1);
        force_en = 1'b0;
        check_eq("dis_pulse", 32'(err_pulse), 0);
        check_eq("dis_cnt", 32'(err_cnt), 9);
        start = 1'b1; step(1);
        start = 1'b0; step(3);
        check_eq("dis_seq", 32'(seq_cnt), 6);
        check_eq("dis_cyc", 32'(cyc), 32'(exp_cyc));
        chk_en = 1'b1;

        reset = 1'b0; step(1);
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            start = 1'($urandom_range(0, 1));
            skip3 = 1'($urandom_range(0, 1));
            wait3 = 1'($urandom_range(0, 1));
            step(1);
        end
        check_eq("soak_err", 32'(err), 0);
        check_eq("soak_cnt", 32'(err_cnt), 0);

        // Drain to IDLE, log one error, then reset mid-S2.
        start = 1'b0; skip3 = 1'b0; wait3 = 1'b0;
        step(4);
        force_en = 1'b1; force_val = 3'b101; step(1);
        force_en = 1'b0;
        check_eq("pre_rst_err", 32'(err), 1);
        start = 1'b1; step(1);
        start = 1'b0; step(1);
        reset = 1'b0; step(1);
        check_zero("mid_rst");
        reset = 1'b1; step(3);
        check_eq("post_rst_err", 32'(err), 0);
        check_eq("post_rst_cyc", 32'(cyc), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
